// File: rtl/lpf_decimator.sv
// Keeps one LPF sample every DECIM clocks and queues it in a small
// first-word-fall-through FIFO; a full FIFO drops kept samples and flags overflow.
module lpf_decimator #(
   parameter int WIDTH = 16,
   parameter int DECIM = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     ready_i,
   input  logic                     clr_ovf_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     valid_o,
   output logic                     ovf_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [PW-1:0]    phase;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             keep;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   assign keep    = (phase == '0);
   assign full    = (level_o == LW'(DEPTH));
   assign valid_o = (level_o != '0);
   assign pop     = valid_o & ready_i;
   // A pop on the same edge frees the slot, so a kept sample is never lost then.
   assign push    = keep & (~full | pop);
   assign drop    = keep & full & ~pop;
   assign data_o  = valid_o ? mem[rd_ptr] : '0;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i)
         phase <= '0;
      else if (phase == PW'(DECIM - 1))
         phase <= '0;
      else
         phase <= phase + PW'(1);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level_o <= level_o + LW'(1);
            2'b01:   level_o <= level_o - LW'(1);
            default: level_o <= level_o;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= data_i;
   end

   // A drop on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i)
         ovf_o <= 1'b0;
      else if (drop)
         ovf_o <= 1'b1;
      else if (clr_ovf_i)
         ovf_o <= 1'b0;
   end

endmodule

// File: tb/tb_lpf_decimator.sv
// Directed bench: one instance at DECIM=4 and one at DECIM=1, both DEPTH=4,
// with hand-computed expected outputs after each clock edge.
module tb_lpf_decimator;

   localparam int W = 16;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          a_rst_n, a_ready, a_clr, a_valid, a_ovf;
   logic [W-1:0]  a_din, a_dout;
   logic [2:0]    a_level;
   logic          b_rst_n, b_ready, b_clr, b_valid, b_ovf;
   logic [W-1:0]  b_din, b_dout;
   logic [2:0]    b_level;

   int n_assert = 0;
   int n_fail   = 0;

   lpf_decimator #(.WIDTH(W), .DECIM(4), .DEPTH(4)) u_dec4 (
      .clk_i(clk), .arst_n_i(a_rst_n), .data_i(a_din), .ready_i(a_ready),
      .clr_ovf_i(a_clr), .data_o(a_dout), .valid_o(a_valid), .ovf_o(a_ovf),
      .level_o(a_level)
   );

   lpf_decimator #(.WIDTH(W), .DECIM(1), .DEPTH(4)) u_dec1 (
      .clk_i(clk), .arst_n_i(b_rst_n), .data_i(b_din), .ready_i(b_ready),
      .clr_ovf_i(b_clr), .data_o(b_dout), .valid_o(b_valid), .ovf_o(b_ovf),
      .level_o(b_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive inputs for the next edge, then land 1 time unit after that edge.
   task automatic edge_a(input logic [W-1:0] d, input logic rdy, input logic clr);
      a_din = d; a_ready = rdy; a_clr = clr;
      @(posedge clk); #1;
   endtask

   task automatic edge_b(input logic [W-1:0] d, input logic rdy);
      b_din = d; b_ready = rdy; b_clr = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int drn_d [6] = '{4, 8, 12, 24, 28, 0};
      int drn_l [6] = '{4, 3, 2, 1, 1, 0};
      int drn_v [6] = '{1, 1, 1, 1, 1, 0};
      int d1_l [13] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 4, 4, 4};
      int d1_h [13] = '{100, 101, 101, 102, 102, 103, 103, 104, 104, 105, 106, 107, 109};
      int d1_o [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

      a_rst_n = 1'b0; a_ready = 1'b0; a_clr = 1'b0; a_din = '0;
      b_rst_n = 1'b0; b_ready = 1'b0; b_clr = 1'b0; b_din = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", a_valid, 0);
      chk("rst_data",  a_dout, 0);
      chk("rst_level", a_level, 0);
      chk("rst_ovf",   a_ovf, 0);
      chk("rst1_valid", b_valid, 0);

      // Free-running with ready=1: one sample of every four, valid for one cycle.
      a_rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         edge_a(W'(i), 1'b1, 1'b0);
         chk("s1_valid", a_valid, (i % 4 == 0));
         chk("s1_data",  a_dout, (i % 4 == 0) ? i : 0);
      end

      // Backpressure: fill, overflow, clear collision, then clean clear.
      a_rst_n = 1'b0; #2; a_rst_n = 1'b1;
      for (int i = 0; i < 24; i++) begin
         edge_a(W'(i), 1'b0, (i == 20 || i == 21));
         if (i % 4 == 0 && i <= 12) chk("fill_level", a_level, i / 4 + 1);
         if (i == 12) chk("ovf_before_drop", a_ovf, 0);
         if (i == 16) begin
            chk("ovf_drop", a_ovf, 1);
            chk("drop_level", a_level, 4);
            chk("drop_head", a_dout, 0);
         end
         if (i == 20) chk("ovf_clr_vs_drop", a_ovf, 1);
         if (i == 21) chk("ovf_clr", a_ovf, 0);
         if (i == 23) begin
            chk("full_valid", a_valid, 1);
            chk("full_head", a_dout, 0);
         end
      end

      // Ready on a keep edge while full: pop+push, then drain.
      for (int k = 0; k < 6; k++) begin
         edge_a(W'(24 + k), 1'b1, 1'b0);
         chk("drain_data",  a_dout, drn_d[k]);
         chk("drain_level", a_level, drn_l[k]);
         chk("drain_valid", a_valid, drn_v[k]);
         if (k == 0) chk("full_pp_ovf", a_ovf, 0);
      end

      // Asynchronous reset mid-operation with three samples stored.
      a_rst_n = 1'b0; #2; a_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) edge_a(W'(i), 1'b0, 1'b0);
      chk("pre_arst_level", a_level, 3);
      #2 a_rst_n = 1'b0;
      #1;
      chk("arst_level", a_level, 0);
      chk("arst_valid", a_valid, 0);
      chk("arst_data",  a_dout, 0);
      a_rst_n = 1'b1;
      edge_a(16'h1234, 1'b0, 1'b0);
      chk("post_arst_valid", a_valid, 1);
      chk("post_arst_data",  a_dout, 16'h1234);
      chk("post_arst_level", a_level, 1);

      // DECIM=1 with toggling ready: net +1 per two edges, overflow, ordered pops.
      b_rst_n = 1'b1;
      for (int k = 0; k < 13; k++) begin
         edge_b(W'(100 + k), (k < 9) ? (k % 2 == 1) : 1'b1);
         chk("d1_level", b_level, d1_l[k]);
         chk("d1_head",  b_dout, d1_h[k]);
         chk("d1_ovf",   b_ovf, d1_o[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
